// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared types and defaults for board-pin conditioning.
// Holds the debounce FSM encoding and the default 12 MHz qualify length.
package io_cond_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_QRISE = 2'd1,
        S_HIGH  = 2'd2,
        S_QFALL = 2'd3
    } deb_state_t;

    // 1 ms of stable input at 12 MHz
    localparam int DEB_CYCLES_12MHZ = 12000;

endpackage

// File: rtl/pin_debounce_edge_if.sv
// pin_debounce_edge_if: raw pin in, conditioned level/strobes out.
// master = debouncer (drives outputs), slave = consumer. EDGE_COUNT
// and its width CNT_W exist only when PIN_EDGE_COUNT_EN is defined.
interface pin_debounce_edge_if;

`ifdef PIN_EDGE_COUNT_EN
    parameter int CNT_W = 16;
    logic [CNT_W-1:0] EDGE_COUNT;
`endif
    logic PIN_IN;
    logic LEVEL_OUT;
    logic RISE_PULSE;
    logic FALL_PULSE;
    logic TOGGLE_OUT;

    modport master (
        input  PIN_IN,
        output LEVEL_OUT,
        output RISE_PULSE,
        output FALL_PULSE,
`ifdef PIN_EDGE_COUNT_EN
        output EDGE_COUNT,
`endif
        output TOGGLE_OUT
    );

    modport slave (
        output PIN_IN,
        input  LEVEL_OUT,
        input  RISE_PULSE,
        input  FALL_PULSE,
`ifdef PIN_EDGE_COUNT_EN
        input  EDGE_COUNT,
`endif
        input  TOGGLE_OUT
    );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous board pin.
// Ports: clk, rst_n (async active-low, resets to 0), d (raw), q (synced).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pin_debounce_edge.sv
// pin_debounce_edge: sync + debounce a raw pin into CLK_IN; emits rise/fall
// strobes, debounced level and toggle. Ports: CLK_IN, RST_N, pins (master).
// Optional rising-edge counter EDGE_COUNT enabled by PIN_EDGE_COUNT_EN.
module pin_debounce_edge
    import io_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_12MHZ
) (
    input  logic                CLK_IN,
    input  logic                RST_N,
    pin_debounce_edge_if.master pins
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             rise_d, fall_d;

    sync_2ff u_sync (
        .clk   (CLK_IN),
        .rst_n (RST_N),
        .d     (pins.PIN_IN),
        .q     (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_QRISE;
                    cnt_d   = '0;
                end
            end
            S_QRISE: begin
                // any low sample aborts; next high restarts from zero
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_QFALL;
                    cnt_d   = '0;
                end
            end
            S_QFALL: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= S_LOW;
            cnt_q           <= '0;
            pins.RISE_PULSE <= 1'b0;
            pins.FALL_PULSE <= 1'b0;
            pins.LEVEL_OUT  <= 1'b0;
            pins.TOGGLE_OUT <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pins.RISE_PULSE <= rise_d;
            pins.FALL_PULSE <= fall_d;
            if (rise_d) begin
                pins.LEVEL_OUT <= 1'b1;
            end else if (fall_d) begin
                pins.LEVEL_OUT <= 1'b0;
            end
            pins.TOGGLE_OUT <= pins.TOGGLE_OUT ^ rise_d;
        end
    end

`ifdef PIN_EDGE_COUNT_EN
    localparam int CW = $bits(pins.EDGE_COUNT);

    // saturating: holds at all-ones instead of wrapping
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            pins.EDGE_COUNT <= '0;
        end else if (rise_d && !(&pins.EDGE_COUNT)) begin
            pins.EDGE_COUNT <= pins.EDGE_COUNT + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pin_debounce_edge.sv
// tb_pin_debounce_edge: directed scenarios plus random pin traffic,
// checked every cycle against a run-length reference model.
module tb_pin_debounce_edge;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

`ifdef PIN_EDGE_COUNT_EN
    pin_debounce_edge_if #(.CNT_W(CW)) pins ();
`else
    pin_debounce_edge_if pins ();
`endif

    pin_debounce_edge #(.DEB_CYCLES(DEB)) dut (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .pins   (pins)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: the FSM sees the pin two samples late; a level
    // change is accepted once the seen value has differed from the
    // accepted level for DEB+1 consecutive samples.
    logic m_p1 = 0, m_p2 = 0, m_lvl = 0, m_tog = 0;
    logic m_rise = 0, m_fall = 0;
    int   m_run = 0, m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1   <= 1'b0;
            m_p2   <= 1'b0;
            m_lvl  <= 1'b0;
            m_tog  <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_run  <= 0;
            m_cnt  <= 0;
        end else begin
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_p1   <= pins.PIN_IN;
            m_p2   <= m_p1;
            if (m_p2 != m_lvl) begin
                if (m_run + 1 == DEB + 1) begin
                    m_run <= 0;
                    m_lvl <= m_p2;
                    if (m_p2) begin
                        m_rise <= 1'b1;
                        m_tog  <= ~m_tog;
                        if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
                    end else begin
                        m_fall <= 1'b1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    int   n_rise = 0, n_fall = 0;
    logic prev_rise = 0, prev_fall = 0;

    always @(negedge clk) begin
        chk("level", int'(pins.LEVEL_OUT), int'(m_lvl));
        chk("rise", int'(pins.RISE_PULSE), int'(m_rise));
        chk("fall", int'(pins.FALL_PULSE), int'(m_fall));
        chk("toggle", int'(pins.TOGGLE_OUT), int'(m_tog));
`ifdef PIN_EDGE_COUNT_EN
        chk("edge_count", int'(pins.EDGE_COUNT), m_cnt);
`endif
        chk("both_strobes", int'(pins.RISE_PULSE & pins.FALL_PULSE), 0);
        chk("rise_twice", int'(prev_rise & pins.RISE_PULSE), 0);
        chk("fall_twice", int'(prev_fall & pins.FALL_PULSE), 0);
        prev_rise = pins.RISE_PULSE;
        prev_fall = pins.FALL_PULSE;
        n_rise += int'(pins.RISE_PULSE);
        n_fall += int'(pins.FALL_PULSE);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // count cycles until RISE_PULSE is seen; 99 means it never came
    task automatic rise_latency(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pins.RISE_PULSE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic reset_pulse(input int n);
        #2 rst_n = 1'b0;
        cyc(n);
        #2 rst_n = 1'b1;
    endtask

    task automatic press(input int hi, input int lo);
        pins.PIN_IN = 1'b1;
        cyc(hi);
        pins.PIN_IN = 1'b0;
        cyc(lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, f0;
        pins.PIN_IN = 1'b0;

        // 1: reset, pin low for 20 cycles
        cyc(3);
        #2 rst_n = 1'b1;
        r0 = n_rise;
        f0 = n_fall;
        cyc(20);
        chk("t1_level", int'(pins.LEVEL_OUT), 0);
        chk("t1_toggle", int'(pins.TOGGLE_OUT), 0);
        chk("t1_strobes", (n_rise - r0) + (n_fall - f0), 0);

        // 2: clean rising edge
        pins.PIN_IN = 1'b1;
        rise_latency(lat);
        chk("t2_latency", lat, 7);
        chk("t2_level", int'(pins.LEVEL_OUT), 1);
        chk("t2_toggle", int'(pins.TOGGLE_OUT), 1);
        cyc(1);
        chk("t2_one_cycle", int'(pins.RISE_PULSE), 0);

        // 3: 3-cycle glitch while low
        pins.PIN_IN = 1'b0;
        cyc(12);
        chk("t3_fell", int'(pins.LEVEL_OUT), 0);
        r0 = n_rise;
        press(3, 12);
        chk("t3_glitch_level", int'(pins.LEVEL_OUT), 0);
        chk("t3_glitch_rise", n_rise - r0, 0);

        // 4: bounce 1,0,1,0 then held 1
        r0 = n_rise;
        for (int i = 0; i < 4; i++) begin
            pins.PIN_IN = (i % 2 == 0);
            cyc(1);
        end
        pins.PIN_IN = 1'b1;
        rise_latency(lat);
        chk("t4_latency", lat, 7);
        cyc(10);
        chk("t4_single_rise", n_rise - r0, 1);

        // 5: three press/release cycles from a fresh reset
        pins.PIN_IN = 1'b0;
        cyc(12);
        reset_pulse(2);
        r0 = n_rise;
        f0 = n_fall;
        for (int i = 0; i < 3; i++) press(10, 10);
        chk("t5_rises", n_rise - r0, 3);
        chk("t5_falls", n_fall - f0, 3);
        chk("t5_toggle", int'(pins.TOGGLE_OUT), 1);
`ifdef PIN_EDGE_COUNT_EN
        chk("t5_edge_count", int'(pins.EDGE_COUNT), 3);
`endif

        // 6: reset during rise qualification
        r0 = n_rise;
        pins.PIN_IN = 1'b1;
        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_level", int'(pins.LEVEL_OUT), 0);
        chk("t6_async_toggle", int'(pins.TOGGLE_OUT), 0);
`ifdef PIN_EDGE_COUNT_EN
        chk("t6_async_count", int'(pins.EDGE_COUNT), 0);
`endif
        cyc(3);
        chk("t6_no_rise", n_rise - r0, 0);
        #2 rst_n = 1'b1;
        rise_latency(lat);
        chk("t6_full_requal", lat, 7);
        pins.PIN_IN = 1'b0;
        cyc(12);
`ifdef PIN_EDGE_COUNT_EN
        // small counter width so saturation is reachable
        for (int i = 0; i < CMAX + 2; i++) press(10, 10);
        chk("t6_saturate", int'(pins.EDGE_COUNT), CMAX);
`endif

        // random traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse(int'($urandom_range(1, 3)));
            end
            pins.PIN_IN = 1'($urandom_range(0, 1));
            cyc(int'($urandom_range(1, 12)));
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
